// File: rtl/dmem_pkg.sv
// Shared constants and region type for the data-memory responder.
// The optional performance counters are selected with the DMEM_PERF_EN macro.
package dmem_pkg;

  localparam logic [31:0] CYCLE_OFS         = 32'h0000_0000;
  localparam logic [31:0] STORES_OFS        = 32'h0000_0004;
  localparam logic [31:0] CTRL_OFS          = 32'h0000_0008;
  localparam logic [31:0] LED_OFS           = 32'h0000_000C;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_CYCLE  = 3'd1,
    REG_STORES = 3'd2,
    REG_CTRL   = 3'd3,
    REG_LED    = 3'd4,
    REG_NONE   = 3'd5
  } dmem_region_t;

  // Word slot inside the 16-byte I/O page to its register.
  function automatic dmem_region_t mmio_region(input logic [1:0] slot);
    dmem_region_t region;
    case (slot)
      CYCLE_OFS[3:2]:  region = REG_CYCLE;
      STORES_OFS[3:2]: region = REG_STORES;
      CTRL_OFS[3:2]:   region = REG_CTRL;
      LED_OFS[3:2]:    region = REG_LED;
      default:         region = REG_NONE;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/dmem_perf_cnt.sv
// Cycle and accepted-store counters; a clear request beats any increment.
// Only instantiated when DMEM_PERF_EN is defined.
module dmem_perf_cnt
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_store_inc,
  output logic [31:0] o_cycle,
  output logic [31:0] o_stores
);

  logic [31:0] r_cycle;
  logic [31:0] r_stores;

  // Free-running cycle count and store count with clear priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle  <= 32'h0;
      r_stores <= 32'h0;
    end else if (i_clr) begin
      r_cycle  <= 32'h0;
      r_stores <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (i_store_inc) begin
        r_stores <= r_stores + 32'd1;
      end else begin
        r_stores <= r_stores;
      end
    end
  end

  assign o_cycle  = r_cycle;
  assign o_stores = r_stores;

endmodule

// File: rtl/dmem_responder.sv
// MIPS data-port responder: word RAM, I/O page (counters, clear, LED) and sticky addr_err.
// Define DMEM_PERF_EN to build the CYCLE/STORES counters and the CTRL clear.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  r_mem [DEPTH];
  logic [7:0]   r_led;
  logic         r_addr_err;

  dmem_region_t w_region;
  logic [29:0]  w_mmio_word;
  logic [AW-1:0] w_ram_idx;
  logic         w_ram_we;
  logic         w_led_we;
  logic         w_bad_store;
  logic [31:0]  w_cycle;
  logic [31:0]  w_stores;
  logic [31:0]  w_rdata;
  logic [1:0]   w_unused_bits;

  assign w_unused_bits = aluout[1:0];
  // Word offset from the page base; wraps harmlessly for addresses below it.
  assign w_mmio_word   = aluout[31:2] - MMIO_BASE[31:2];
  assign w_ram_idx     = aluout[AW+1:2];

  // Address decode: RAM first, then the four-word I/O page.
  always_comb begin
    w_region = REG_NONE;
    if (aluout[31:AW+2] == {(30-AW){1'b0}}) begin
      w_region = REG_RAM;
    end else if (w_mmio_word[29:2] == 28'h0) begin
      w_region = mmio_region(w_mmio_word[1:0]);
    end else begin
      w_region = REG_NONE;
    end
  end

  assign w_ram_we    = memwrite && (w_region == REG_RAM);
  assign w_led_we    = memwrite && (w_region == REG_LED);
  assign w_bad_store = memwrite && ((w_region == REG_CYCLE) ||
                                    (w_region == REG_STORES) ||
                                    (w_region == REG_NONE));

`ifdef DMEM_PERF_EN
  logic w_clr;
  assign w_clr = memwrite && (w_region == REG_CTRL) && writedata[0];

  dmem_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_clr),
    .i_store_inc (w_ram_we),
    .o_cycle     (w_cycle),
    .o_stores    (w_stores)
  );
`else
  assign w_cycle  = 32'h0;
  assign w_stores = 32'h0;
`endif

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= writedata;
    end
  end

  // LED register and sticky store-error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led      <= 8'h00;
      r_addr_err <= 1'b0;
    end else begin
      if (w_led_we) begin
        r_led <= writedata[7:0];
      end else begin
        r_led <= r_led;
      end
      if (w_bad_store) begin
        r_addr_err <= 1'b1;
      end else begin
        r_addr_err <= r_addr_err;
      end
    end
  end

  // Zero-latency load mux; unmapped and write-only locations read as zero.
  always_comb begin
    w_rdata = 32'h0;
    case (w_region)
      REG_RAM:    w_rdata = r_mem[w_ram_idx];
      REG_CYCLE:  w_rdata = w_cycle;
      REG_STORES: w_rdata = w_stores;
      REG_LED:    w_rdata = {24'h0, r_led};
      REG_CTRL:   w_rdata = 32'h0;
      default:    w_rdata = 32'h0;
    endcase
  end

  assign readdata = w_rdata;
  assign led      = r_led;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=64, default MMIO_BASE).
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DMEM_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led;
  logic        addr_err;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH(64), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    aluout = addr;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    tick(); tick();
    chk("reset_led", {24'h0, led}, 32'h0);
    chk("reset_err", {31'h0, addr_err}, 32'h0);
    rd("reset_cycle", MB, 32'h0);
    rd("reset_stores", MB + 32'h4, 32'h0);

    reset = 1'b1;
    repeat (100) tick();
    rd("cycle_100", MB, PERF ? 32'd100 : 32'd0);

    memwrite = 1'b1; aluout = MB + 32'h8; writedata = 32'h1;
    #1 chk("ctrl_read0", readdata, 32'h0);
    tick();
    memwrite = 1'b0;
    rd("cycle_cleared", MB, 32'h0);
    rd("stores_cleared", MB + 32'h4, 32'h0);
    tick();
    rd("cycle_after_clr", MB, PERF ? 32'd1 : 32'd0);

    memwrite = 1'b1; aluout = 32'h0; writedata = 32'hCAFE_0000;
    tick();
    aluout = 32'h10; writedata = 32'h1111_1111;
    tick();
    writedata = 32'hDEAD_BEEF;
    #1 chk("same_cycle_old", readdata, 32'h1111_1111);
    tick();
    memwrite = 1'b0;
    #1 chk("next_cycle_new", readdata, 32'hDEAD_BEEF);
    memwrite = 1'b1; aluout = 32'h17; writedata = 32'h0BAD_F00D;
    tick();
    memwrite = 1'b0;
    rd("low_bits_ignored", 32'h14, 32'h0BAD_F00D);
    rd("stores_4", MB + 32'h4, PERF ? 32'd4 : 32'd0);
    rd("ram_word0", 32'h0, 32'hCAFE_0000);

    memwrite = 1'b1; aluout = MB + 32'hC; writedata = 32'h0000_01A5;
    tick();
    memwrite = 1'b0;
    #1 chk("led_out", {24'h0, led}, 32'hA5);
    chk("led_read", readdata, 32'hA5);
    rd("stores_after_led", MB + 32'h4, PERF ? 32'd4 : 32'd0);
    rd("unmapped_read", 32'h2000, 32'h0);
    chk("read_no_err", {31'h0, addr_err}, 32'h0);

    memwrite = 1'b1; aluout = 32'h100; writedata = 32'h1234_5678;
    tick();
    memwrite = 1'b0;
    #1 chk("unmapped_store_err", {31'h0, addr_err}, 32'h1);
    rd("no_alias_write", 32'h0, 32'hCAFE_0000);
    rd("stores_not_bumped", MB + 32'h4, PERF ? 32'd4 : 32'd0);
    repeat (50) tick();
    chk("err_sticky", {31'h0, addr_err}, 32'h1);

    reset = 1'b0;
    #1 chk("async_err_clr", {31'h0, addr_err}, 32'h0);
    chk("async_led_clr", {24'h0, led}, 32'h0);
    tick();
    reset = 1'b1;
    rd("cycle_after_rst", MB, 32'h0);
    rd("ram_kept", 32'h10, 32'hDEAD_BEEF);

    memwrite = 1'b1; aluout = MB + 32'h8; writedata = 32'h0;
    tick();
    memwrite = 1'b0;
    #1 chk("ctrl_store_ok", {31'h0, addr_err}, 32'h0);
    memwrite = 1'b1; aluout = MB + 32'h4; writedata = 32'h7;
    tick();
    memwrite = 1'b0;
    #1 chk("ro_store_err", {31'h0, addr_err}, 32'h1);
    rd("stores_ro_dropped", MB + 32'h4, 32'h0);
    rd("page_hole", MB + 32'h10, 32'h0);

`ifdef DMEM_PERF_EN
    aluout = MB;
    force dut.u_perf.r_cycle = 32'hFFFF_FFFF;
    #1 release dut.u_perf.r_cycle;
    #1 chk("cycle_forced", readdata, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", readdata, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
